// File: rtl/next_addr_ctrl.sv
// Next-address sequencer control for a bit-slice microprogram sequencer: decodes
// the 16 next-address ops and tracks loop counter and slice stack depth. Optional: NAC_STACK_GUARD_EN.
module next_addr_ctrl (
    input  logic        CP,
    input  logic        RST,
    input  logic        CE,
    input  logic [3:0]  I,
    input  logic        TEST,
    input  logic [11:0] CNT_D,
    output logic [1:0]  S,
    output logic        FE_N,
    output logic        PUP,
    output logic        ZERO_N,
    output logic        PL_N,
    output logic        MAP_N,
    output logic        VECT_N,
    output logic        CNT_Z,
    output logic [2:0]  DEPTH,
    output logic        OVF,
    output logic        UNF
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned DEPTH_W = 3;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(4);

    typedef enum logic [3:0] {
        OP_JZ   = 4'h0, OP_CJS  = 4'h1, OP_JMAP = 4'h2, OP_CJP  = 4'h3,
        OP_PUSH = 4'h4, OP_JSRP = 4'h5, OP_CJV  = 4'h6, OP_JRP  = 4'h7,
        OP_RFCT = 4'h8, OP_RPCT = 4'h9, OP_CRTN = 4'hA, OP_CJPP = 4'hB,
        OP_LDCT = 4'hC, OP_LOOP = 4'hD, OP_CONT = 4'hE, OP_TWB  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        SRC_UPC = 2'b00,
        SRC_R   = 2'b01,
        SRC_STK = 2'b10,
        SRC_D   = 2'b11
    } src_e;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    src_e src;
    logic push, pop, zero_n, map_sel, vect_sel, cnt_load, cnt_dec;
    logic cnt_nz, ovf_hit, unf_hit, stk_blk;

    assign cnt_nz = (count_q != '0);

    // Instruction decode: source select, stack op and counter action
    always_comb begin
        src      = SRC_UPC;
        push     = 1'b0;
        pop      = 1'b0;
        zero_n   = 1'b1;
        map_sel  = 1'b0;
        vect_sel = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (op_e'(I))
            OP_JZ:   zero_n = 1'b0;
            OP_CJS:  begin push = TEST; src = TEST ? SRC_D : SRC_UPC; end
            OP_JMAP: begin src = SRC_D; map_sel = 1'b1; end
            OP_CJP:  src = TEST ? SRC_D : SRC_UPC;
            OP_PUSH: begin push = 1'b1; cnt_load = TEST; end
            OP_JSRP: begin push = 1'b1; src = TEST ? SRC_D : SRC_R; end
            OP_CJV:  begin src = TEST ? SRC_D : SRC_UPC; vect_sel = TEST; end
            OP_JRP:  src = TEST ? SRC_D : SRC_R;
            OP_RFCT: begin
                src     = cnt_nz ? SRC_STK : SRC_UPC;
                cnt_dec = cnt_nz;
                pop     = !cnt_nz;
            end
            OP_RPCT: begin
                src     = cnt_nz ? SRC_D : SRC_UPC;
                cnt_dec = cnt_nz;
            end
            OP_CRTN: begin src = TEST ? SRC_STK : SRC_UPC; pop = TEST; end
            OP_CJPP: begin src = TEST ? SRC_D : SRC_UPC; pop = TEST; end
            OP_LDCT: cnt_load = 1'b1;
            OP_LOOP: begin src = TEST ? SRC_UPC : SRC_STK; pop = TEST; end
            OP_CONT: src = SRC_UPC;
            OP_TWB: begin
                if (TEST) begin
                    pop = 1'b1;
                end else if (cnt_nz) begin
                    src     = SRC_STK;
                    cnt_dec = 1'b1;
                end else begin
                    src = SRC_D;
                    pop = 1'b1;
                end
            end
        endcase
    end

    assign ovf_hit = push && (depth_q == DEPTH_MAX);
    assign unf_hit = pop && (depth_q == '0);

`ifdef NAC_STACK_GUARD_EN
    assign stk_blk = ovf_hit || unf_hit;
`else
    assign stk_blk = 1'b0;
`endif

    // Slice controls are combinational so the slices see them in the same cycle
    assign S      = src;
    assign PUP    = push;
    assign ZERO_N = zero_n;
    assign FE_N   = !((push || pop) && CE && !RST && !stk_blk);
    assign PL_N   = !((src == SRC_D) && !map_sel && !vect_sel);
    assign MAP_N  = !((src == SRC_D) && map_sel);
    assign VECT_N = !((src == SRC_D) && vect_sel);

    // Counter and stack-depth next state; out-of-range stack ops only set flags
    always_comb begin
        count_d = count_q;
        depth_d = depth_q;
        ovf_d   = ovf_q || ovf_hit;
        unf_d   = unf_q || unf_hit;
        if (cnt_load) begin
            count_d = CNT_D;
        end else if (cnt_dec && cnt_nz) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push && !ovf_hit) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && !unf_hit) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            count_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (CE) begin
            count_q <= count_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign CNT_Z = (count_q == '0);
    assign DEPTH = depth_q;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;

endmodule
